risc8_fetch: RTL and testbench

Instruction fetch and prefetch unit for the RISC-8 core, feeding the instruction decoder. It reads 16-bit words from synchronous program memory into a small prefetch queue and pre-decodes each head word to detect two-word instructions (LDS, STS, JMP, CALL). It then presents one complete instruction per handshake: opcode, second word and PC. Control flow redirects (jumps, calls, returns, taken branches, skips) flush the queue and restart fetch at the new address.

---
 rtl/risc8_fetch_if.sv | 29 ++
 rtl/risc8_fetch.sv | 150 +++++++++++++++
 tb/tb_risc8_fetch.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/risc8_fetch_if.sv
// Bus bundle between the RISC-8 fetch unit, program memory and the decoder.
// The master side is the fetch unit; the slave side is memory plus decoder.
interface risc8_fetch_if #(
  parameter int ADDR_W = 13
);
  // program memory read port
  logic              pmem_rd;
  logic [ADDR_W-1:0] pmem_addr;
  logic [15:0]       pmem_data;
  // instruction hand-off to the decoder
  logic              opcode_valid;
  logic              opcode_ready;
  logic [15:0]       opcode;
  logic [15:0]       opcode_arg;
  logic [ADDR_W-1:0] opcode_pc;
  // control flow redirect
  logic              jump_valid;
  logic [ADDR_W-1:0] jump_addr;

  modport master (
    output pmem_rd, pmem_addr, opcode_valid, opcode, opcode_arg, opcode_pc,
    input  pmem_data, opcode_ready, jump_valid, jump_addr
  );

  modport slave (
    input  pmem_rd, pmem_addr, opcode_valid, opcode, opcode_arg, opcode_pc,
    output pmem_data, opcode_ready, jump_valid, jump_addr
  );
endinterface

// File: rtl/risc8_fetch.sv
// RISC-8 instruction fetch / prefetch unit.
// Streams 16-bit words from synchronous program memory into a small circular
// queue, pre-decodes the head word to find two-word instructions and hands
// one complete instruction per handshake to the decoder. A redirect flushes
// the queue and drops the read that is in flight.
module risc8_fetch #(
  parameter int ADDR_W = 13,
  parameter int DEPTH  = 4
) (
  input logic           clk,
  input logic           reset_n,
  risc8_fetch_if.master bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  // Two-word encodings: LDS/STS (1001_00xx_xxxx_0000) and JMP/CALL
  // (1001_010x_xxxx_11xx); bit 1 selects CALL over JMP, so it is not part of
  // the length decision.
  function automatic logic is_two_word(input logic [15:0] w);
    logic lds_sts;
    logic jmp_call;
    lds_sts  = (w[15:10] == 6'b100100)  && (w[3:0] == 4'b0000);
    jmp_call = (w[15:9]  == 7'b1001010) && (w[3:2] == 2'b11);
    return lds_sts || jmp_call;
  endfunction

  logic [15:0]       r_word [DEPTH];
  logic [ADDR_W-1:0] r_pc   [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic              r_pending;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_fill_pc;

  logic [CNT_W:0]    w_occ;
  logic              w_issue;
  logic [15:0]       w_head_word;
  logic [15:0]       w_next_word;
  logic [ADDR_W-1:0] w_head_pc;
  logic              w_two;
  logic              w_valid;
  logic              w_pop;
  logic [CNT_W-1:0]  w_pop_n;
  logic [CNT_W-1:0]  w_fill_n;

  // Read issue decision, taken from registered occupancy only.
  always_comb begin
    w_occ   = {1'b0, r_count} + {{CNT_W{1'b0}}, r_pending};
    w_issue = (w_occ < (CNT_W+1)'(DEPTH));
  end

  // Head pre-decode, handshake and per-cycle pop/fill amounts.
  always_comb begin
    w_head_word = r_word[r_head];
    w_next_word = r_word[r_head + PTR_W'(1)];
    w_head_pc   = r_pc[r_head];
    w_two       = is_two_word(w_head_word);
    w_valid     = 1'b0;
    w_pop_n     = {CNT_W{1'b0}};
    if (w_two) begin
      w_valid = (r_count >= CNT_W'(2));
    end else begin
      w_valid = (r_count >= CNT_W'(1));
    end
    w_pop = w_valid & bus.opcode_ready;
    if (!w_pop) begin
      w_pop_n = CNT_W'(0);
    end else if (w_two) begin
      w_pop_n = CNT_W'(2);
    end else begin
      w_pop_n = CNT_W'(1);
    end
    if (r_pending) begin
      w_fill_n = CNT_W'(1);
    end else begin
      w_fill_n = CNT_W'(0);
    end
  end

  // Decoder-facing outputs; a NOP with zero arg/pc whenever nothing is ready.
  always_comb begin
    bus.opcode_valid = w_valid;
    bus.opcode       = 16'h0000;
    bus.opcode_arg   = 16'h0000;
    bus.opcode_pc    = {ADDR_W{1'b0}};
    if (w_valid) begin
      bus.opcode    = w_head_word;
      bus.opcode_pc = w_head_pc;
      if (w_two) begin
        bus.opcode_arg = w_next_word;
      end else begin
        bus.opcode_arg = 16'h0000;
      end
    end else begin
      bus.opcode_arg = 16'h0000;
    end
  end

  // Memory port; the strobe is held low while reset is asserted.
  assign bus.pmem_rd   = w_issue & reset_n;
  assign bus.pmem_addr = r_fetch_pc;

  // Fetch PC, in-flight flag and queue pointers; redirect overrides pop/fill.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fetch_pc <= {ADDR_W{1'b0}};
      r_fill_pc  <= {ADDR_W{1'b0}};
      r_pending  <= 1'b0;
      r_head     <= {PTR_W{1'b0}};
      r_tail     <= {PTR_W{1'b0}};
      r_count    <= {CNT_W{1'b0}};
    end else if (bus.jump_valid) begin
      r_fetch_pc <= bus.jump_addr;
      r_pending  <= 1'b0;
      r_head     <= {PTR_W{1'b0}};
      r_tail     <= {PTR_W{1'b0}};
      r_count    <= {CNT_W{1'b0}};
    end else begin
      if (w_issue) begin
        r_fetch_pc <= r_fetch_pc + ADDR_W'(1);
        r_fill_pc  <= r_fetch_pc;
        r_pending  <= 1'b1;
      end else begin
        r_pending  <= 1'b0;
      end
      if (r_pending) begin
        r_tail <= r_tail + PTR_W'(1);
      end
      r_head  <= r_head + PTR_W'(w_pop_n);
      r_count <= r_count + w_fill_n - w_pop_n;
    end
  end

  // Queue storage: the returning word and its address land at the tail.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_word[i] <= 16'h0000;
        r_pc[i]   <= {ADDR_W{1'b0}};
      end
    end else if (r_pending && !bus.jump_valid) begin
      r_word[r_tail] <= bus.pmem_data;
      r_pc[r_tail]   <= r_fill_pc;
    end
  end

endmodule

// File: tb/tb_risc8_fetch.sv
// Directed self-checking bench for risc8_fetch with a synchronous memory model.
module tb_risc8_fetch;

  localparam int ADDR_W = 13;

  logic clk;
  logic reset_n;
  int   n_total;
  int   n_bad;
  logic [15:0] mem [1 << ADDR_W];

  risc8_fetch_if #(.ADDR_W(ADDR_W)) bus ();

  risc8_fetch #(.ADDR_W(ADDR_W), .DEPTH(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous program memory: data one cycle after the strobe
  always @(posedge clk) begin
    if (bus.pmem_rd) bus.pmem_data <= mem[bus.pmem_addr];
    else             bus.pmem_data <= 16'hDEAD;
  end

  // expected stream after reset, indexed by cycle number (0 = first cycle)
  logic        e_v   [16] = '{1'b0,1'b0,1'b1,1'b1,1'b1,1'b1,1'b0,1'b1,
                              1'b1,1'b1,1'b0,1'b1,1'b1,1'b0,1'b1,1'b1};
  logic [12:0] e_pc  [16] = '{13'd0,13'd0,13'd0,13'd1,13'd2,13'd3,13'd0,13'd4,
                              13'd6,13'd7,13'd0,13'd8,13'd10,13'd0,13'd11,13'd13};
  logic [15:0] e_op  [16] = '{16'h0000,16'h0000,16'h1000,16'h1001,16'h1002,16'h1003,
                              16'h0000,16'h940C,16'h1006,16'h1007,16'h0000,16'h9100,
                              16'h100A,16'h0000,16'h9200,16'h100D};
  logic [15:0] e_arg [16] = '{16'h0000,16'h0000,16'h0000,16'h0000,16'h0000,16'h0000,
                              16'h0000,16'h0123,16'h0000,16'h0000,16'h0000,16'h0456,
                              16'h0000,16'h0000,16'h0789,16'h0000};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_idle_zero(input string tag);
    check_val({tag, "_rd"},    32'(bus.pmem_rd),      32'd0);
    check_val({tag, "_addr"},  32'(bus.pmem_addr),    32'd0);
    check_val({tag, "_valid"}, 32'(bus.opcode_valid), 32'd0);
    check_val({tag, "_op"},    32'(bus.opcode),       32'd0);
    check_val({tag, "_arg"},   32'(bus.opcode_arg),   32'd0);
    check_val({tag, "_pc"},    32'(bus.opcode_pc),    32'd0);
  endtask

  // wait (bounded) for a valid head with ready held high, compare, let it pop
  task automatic expect_hs(input string tag, input logic [12:0] pc,
                           input logic [15:0] op, input logic [15:0] arg);
    int n;
    n = 0;
    while (!bus.opcode_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!bus.opcode_valid) begin
      check_val({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      check_val({tag, "_pc"},  32'(bus.opcode_pc),  32'(pc));
      check_val({tag, "_op"},  32'(bus.opcode),     32'(op));
      check_val({tag, "_arg"}, 32'(bus.opcode_arg), 32'(arg));
    end
    @(negedge clk);
  endtask

  task automatic redirect(input logic [12:0] addr);
    bus.jump_valid = 1'b1;
    bus.jump_addr  = addr;
    @(negedge clk);
    bus.jump_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    n_total = 0;
    n_bad   = 0;
    for (int a = 0; a < (1 << ADDR_W); a++) mem[a] = 16'h1000 | {4'h0, 12'(a)};
    mem[4]  = 16'h940C; mem[5]  = 16'h0123;   // JMP
    mem[8]  = 16'h9100; mem[9]  = 16'h0456;   // LDS
    mem[11] = 16'h9200; mem[12] = 16'h0789;   // STS

    bus.opcode_ready = 1'b1;
    bus.jump_valid   = 1'b0;
    bus.jump_addr    = 13'd0;
    reset_n          = 1'b0;

    // reset state
    #12;
    check_idle_zero("rst");

    // reset release and streaming with two-word decode
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_val("c0_rd",   32'(bus.pmem_rd),   32'd1);
    check_val("c0_addr", 32'(bus.pmem_addr), 32'd0);
    check_val("c0_valid", 32'(bus.opcode_valid), 32'd0);
    for (int k = 1; k < 16; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check_val("c1_rd",   32'(bus.pmem_rd),   32'd1);
        check_val("c1_addr", 32'(bus.pmem_addr), 32'd1);
      end
      check_val($sformatf("s%0d_valid", k), 32'(bus.opcode_valid), 32'(e_v[k]));
      check_val($sformatf("s%0d_pc", k),    32'(bus.opcode_pc),    32'(e_pc[k]));
      check_val($sformatf("s%0d_op", k),    32'(bus.opcode),       32'(e_op[k]));
      check_val($sformatf("s%0d_arg", k),   32'(bus.opcode_arg),   32'(e_arg[k]));
    end

    // backpressure until full
    bus.opcode_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_val("full_rd",   32'(bus.pmem_rd),   32'd0);
    check_val("full_addr", 32'(bus.pmem_addr), 32'd17);
    check_val("full_pc",   32'(bus.opcode_pc), 32'd13);
    @(negedge clk);
    bus.opcode_ready = 1'b1;
    @(negedge clk);
    bus.opcode_ready = 1'b0;
    check_val("free_rd",   32'(bus.pmem_rd),   32'd1);
    check_val("free_addr", 32'(bus.pmem_addr), 32'd17);
    check_val("free_pc",   32'(bus.opcode_pc), 32'd14);
    @(negedge clk);
    check_val("refull_rd",   32'(bus.pmem_rd),   32'd0);
    check_val("refull_addr", 32'(bus.pmem_addr), 32'd18);
    bus.opcode_ready = 1'b1;
    expect_hs("bp14", 13'd14, 16'h100E, 16'h0000);
    expect_hs("bp15", 13'd15, 16'h100F, 16'h0000);
    expect_hs("bp16", 13'd16, 16'h1010, 16'h0000);
    expect_hs("bp17", 13'd17, 16'h1011, 16'h0000);

    // redirect while full with a read in flight and ready high
    bus.opcode_ready = 1'b0;
    repeat (6) @(negedge clk);
    bus.opcode_ready = 1'b1;
    @(negedge clk);
    bus.opcode_ready = 1'b0;
    @(negedge clk);
    check_val("jfull_rd", 32'(bus.pmem_rd), 32'd0);
    bus.opcode_ready = 1'b1;
    redirect(13'h100);
    check_val("j1_rd",    32'(bus.pmem_rd),      32'd1);
    check_val("j1_addr",  32'(bus.pmem_addr),    32'h100);
    check_val("j1_valid", 32'(bus.opcode_valid), 32'd0);
    @(negedge clk);
    check_val("j2_valid", 32'(bus.opcode_valid), 32'd0);
    @(negedge clk);
    check_val("j3_valid", 32'(bus.opcode_valid), 32'd1);
    expect_hs("j100", 13'h100, 16'h1100, 16'h0000);
    expect_hs("j101", 13'h101, 16'h1101, 16'h0000);
    expect_hs("j102", 13'h102, 16'h1102, 16'h0000);

    // PC wrap-around, one-word then two-word at the top address
    redirect(13'h1FFF);
    expect_hs("w1fff", 13'h1FFF, 16'h1FFF, 16'h0000);
    expect_hs("w0000", 13'h0000, 16'h1000, 16'h0000);
    mem[13'h1FFF] = 16'h940E;   // CALL, arg comes from address 0
    redirect(13'h1FFF);
    expect_hs("w2_1fff", 13'h1FFF, 16'h940E, 16'h1000);
    expect_hs("w2_0001", 13'h0001, 16'h1001, 16'h0000);

    // asynchronous reset between edges with data queued and a read pending
    bus.opcode_ready = 1'b0;
    redirect(13'h200);
    @(negedge clk);
    @(negedge clk);
    check_val("ar_pre_valid", 32'(bus.opcode_valid), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_idle_zero("ar");
    @(negedge clk);
    reset_n = 1'b1;
    bus.opcode_ready = 1'b1;
    #1;
    check_val("ar_c0_rd",   32'(bus.pmem_rd),   32'd1);
    check_val("ar_c0_addr", 32'(bus.pmem_addr), 32'd0);
    @(negedge clk);
    check_val("ar_c1_valid", 32'(bus.opcode_valid), 32'd0);
    @(negedge clk);
    check_val("ar_c2_valid", 32'(bus.opcode_valid), 32'd1);
    expect_hs("ar0", 13'd0, 16'h1000, 16'h0000);
    expect_hs("ar1", 13'd1, 16'h1001, 16'h0000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
